icache_cacop_unit: RTL and testbench

ICACHE_CACOP_UNIT -- requirements
Module: icache_cacop_unit

---
 rtl/icache_cacop_unit.sv | 171 +++++++++++++++++
 tb/tb_icache_cacop_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/icache_cacop_unit.sv
// ICache CACOP unit: runs the cacop instruction from the memory pipeline
// against the ICache tag SRAM.
// Modes:
//   0 / 1  write an invalid tag into the way picked by vaddr's low bits
//   2      translate vaddr, read tags, clear every way whose tag matches
//   3      no-op
// The fetch pipeline is stalled whenever the unit is not idle.
module icache_cacop_unit #(
  parameter int WAY_NUM   = 2,
  parameter int IDX_WIDTH = 8,
  parameter int TAG_WIDTH = 20
) (
  input  logic                                clk,
  input  logic                                a_rst_n,
  input  logic                                flush_i,
  // request from memory stage 1
  input  logic                                req_valid_i,
  input  logic [31:0]                         req_vaddr_i,
  input  logic [5:0]                          req_rob_idx_i,
  input  logic [1:0]                          req_mode_i,
  input  logic                                req_ready_i,
  // response towards writeback
  output logic                                rsp_ready_o,
  output logic                                rsp_valid_o,
  output logic [5:0]                          rsp_rob_idx_o,
  output logic [31:0]                         rsp_vaddr_o,
  output logic [6:0]                          rsp_excp_o,
  // MMU translation
  output logic                                trans_req_valid_o,
  output logic [31:0]                         trans_req_vaddr_o,
  input  logic                                trans_rsp_valid_i,
  input  logic [31:0]                         trans_rsp_paddr_i,
  input  logic [6:0]                          trans_rsp_excp_i,
  // tag SRAM port, entries are {valid, tag}
  output logic                                tag_en_o,
  output logic [WAY_NUM-1:0]                  tag_we_o,
  output logic [IDX_WIDTH-1:0]                tag_addr_o,
  output logic [TAG_WIDTH:0]                  tag_wdata_o,
  input  logic [WAY_NUM-1:0][TAG_WIDTH:0]     tag_rdata_i,
  output logic                                fetch_stall_o
);

  localparam int WAY_BITS = (WAY_NUM > 1) ? $clog2(WAY_NUM) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    TRANS   = 3'd1,
    COMPARE = 3'd2,
    WRITE   = 3'd3,
    RESP    = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [31:0]           vaddr_q, vaddr_d;
  logic [5:0]            rob_q, rob_d;
  logic [TAG_WIDTH-1:0]  ptag_q, ptag_d;
  logic [6:0]            excp_q, excp_d;

  logic [WAY_NUM-1:0]    hit;
  logic [WAY_NUM-1:0]    way_onehot;
  logic [WAY_BITS-1:0]   way_sel;
  logic                  unused_paddr;

  // Only the tag part of the physical address matters for the compare.
  assign unused_paddr = ^trans_rsp_paddr_i;

  assign way_sel = vaddr_q[WAY_BITS-1:0];

  // Per-way tag match and index-mode way decode.
  for (genvar gi = 0; gi < WAY_NUM; gi++) begin : g_way
    assign hit[gi]        = tag_rdata_i[gi][TAG_WIDTH] &
                            (tag_rdata_i[gi][TAG_WIDTH-1:0] == ptag_q);
    assign way_onehot[gi] = (way_sel == WAY_BITS'(gi));
  end

  assign tag_addr_o        = vaddr_q[4 +: IDX_WIDTH];
  assign tag_wdata_o       = '0;
  assign trans_req_vaddr_o = vaddr_q;
  assign rsp_rob_idx_o     = rob_q;
  assign rsp_vaddr_o       = vaddr_q;
  assign rsp_excp_o        = excp_q;
  assign rsp_ready_o       = (state_q == IDLE);
  assign fetch_stall_o     = (state_q != IDLE);

  // Next-state, latched fields and SRAM/MMU strobes.
  always_comb begin
    state_d           = state_q;
    vaddr_d           = vaddr_q;
    rob_d             = rob_q;
    ptag_d            = ptag_q;
    excp_d            = excp_q;
    tag_en_o          = 1'b0;
    tag_we_o          = '0;
    trans_req_valid_o = 1'b0;
    rsp_valid_o       = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          vaddr_d = req_vaddr_i;
          rob_d   = req_rob_idx_i;
          excp_d  = '0;
          case (req_mode_i)
            2'd0, 2'd1: state_d = WRITE;
            2'd2:       state_d = TRANS;
            default:    state_d = RESP;
          endcase
        end
      end
      WRITE: begin
        tag_en_o = 1'b1;
        tag_we_o = way_onehot;
        state_d  = RESP;
      end
      TRANS: begin
        trans_req_valid_o = 1'b1;
        if (trans_rsp_valid_i) begin
          if (trans_rsp_excp_i[6]) begin
            excp_d  = trans_rsp_excp_i;
            state_d = RESP;
          end else begin
            // Tag read issued now; data arrives in COMPARE.
            ptag_d   = trans_rsp_paddr_i[31 -: TAG_WIDTH];
            tag_en_o = 1'b1;
            state_d  = COMPARE;
          end
        end
      end
      COMPARE: begin
        if (|hit) begin
          tag_en_o = 1'b1;
          tag_we_o = hit;
        end
        state_d = RESP;
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        if (req_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Flush abandons everything (including acceptance in IDLE); a tag write
    // already on the SRAM port this cycle is left to complete.
    if (flush_i) begin
      state_d     = IDLE;
      vaddr_d     = vaddr_q;
      rob_d       = rob_q;
      excp_d      = '0;
      rsp_valid_o = 1'b0;
    end
  end

  // State and latched request fields.
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      state_q <= IDLE;
      vaddr_q <= '0;
      rob_q   <= '0;
      ptag_q  <= '0;
      excp_q  <= '0;
    end else begin
      state_q <= state_d;
      vaddr_q <= vaddr_d;
      rob_q   <= rob_d;
      ptag_q  <= ptag_d;
      excp_q  <= excp_d;
    end
  end

endmodule

// File: tb/tb_icache_cacop_unit.sv
// Directed self-checking bench for icache_cacop_unit.
module tb_icache_cacop_unit;

  logic               clk = 1'b0;
  logic               a_rst_n;
  logic               flush_i;
  logic               req_valid_i;
  logic [31:0]        req_vaddr_i;
  logic [5:0]         req_rob_idx_i;
  logic [1:0]         req_mode_i;
  logic               req_ready_i;
  logic               rsp_ready_o;
  logic               rsp_valid_o;
  logic [5:0]         rsp_rob_idx_o;
  logic [31:0]        rsp_vaddr_o;
  logic [6:0]         rsp_excp_o;
  logic               trans_req_valid_o;
  logic [31:0]        trans_req_vaddr_o;
  logic               trans_rsp_valid_i;
  logic [31:0]        trans_rsp_paddr_i;
  logic [6:0]         trans_rsp_excp_i;
  logic               tag_en_o;
  logic [1:0]         tag_we_o;
  logic [7:0]         tag_addr_o;
  logic [20:0]        tag_wdata_o;
  logic [1:0][20:0]   tag_rdata_i;
  logic               fetch_stall_o;

  int errors = 0;
  int checks = 0;

  icache_cacop_unit #(.WAY_NUM(2), .IDX_WIDTH(8), .TAG_WIDTH(20)) dut (
    .clk(clk), .a_rst_n(a_rst_n), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_vaddr_i(req_vaddr_i),
    .req_rob_idx_i(req_rob_idx_i), .req_mode_i(req_mode_i),
    .req_ready_i(req_ready_i), .rsp_ready_o(rsp_ready_o),
    .rsp_valid_o(rsp_valid_o), .rsp_rob_idx_o(rsp_rob_idx_o),
    .rsp_vaddr_o(rsp_vaddr_o), .rsp_excp_o(rsp_excp_o),
    .trans_req_valid_o(trans_req_valid_o), .trans_req_vaddr_o(trans_req_vaddr_o),
    .trans_rsp_valid_i(trans_rsp_valid_i), .trans_rsp_paddr_i(trans_rsp_paddr_i),
    .trans_rsp_excp_i(trans_rsp_excp_i), .tag_en_o(tag_en_o),
    .tag_we_o(tag_we_o), .tag_addr_o(tag_addr_o), .tag_wdata_o(tag_wdata_o),
    .tag_rdata_i(tag_rdata_i), .fetch_stall_o(fetch_stall_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] mode, input logic [31:0] va, input logic [5:0] rob);
    req_valid_i   = 1'b1;
    req_mode_i    = mode;
    req_vaddr_i   = va;
    req_rob_idx_i = rob;
    tick();
    req_valid_i   = 1'b0;
  endtask

  task automatic test_reset();
    a_rst_n = 1'b0;
    #3;
    checks++; if (rsp_ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b exp 1", rsp_ready_o); end
    checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b exp 0", rsp_valid_o); end
    checks++; if ({tag_en_o, tag_we_o, trans_req_valid_o, fetch_stall_o} !== 5'b0) begin errors++; $display("FAIL rst_strobes: got %b exp 00000", {tag_en_o, tag_we_o, trans_req_valid_o, fetch_stall_o}); end
    checks++; if ({rsp_rob_idx_o, rsp_vaddr_o, rsp_excp_o} !== 45'd0) begin errors++; $display("FAIL rst_fields: got %h exp 0", {rsp_rob_idx_o, rsp_vaddr_o, rsp_excp_o}); end
    #9 a_rst_n = 1'b1;
    tick();
    $display("reset: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_index_inval();
    checks++; if (rsp_ready_o !== 1'b1) begin errors++; $display("FAIL m1_ready: got %b exp 1", rsp_ready_o); end
    issue(2'd1, 32'h0000_0A31, 6'd5);
    checks++; if ({tag_en_o, tag_we_o} !== 3'b110) begin errors++; $display("FAIL m1_we: got %b exp 110", {tag_en_o, tag_we_o}); end
    checks++; if (tag_addr_o !== 8'hA3) begin errors++; $display("FAIL m1_addr: got %h exp a3", tag_addr_o); end
    checks++; if (tag_wdata_o !== 21'd0) begin errors++; $display("FAIL m1_wdata: got %h exp 0", tag_wdata_o); end
    checks++; if ({rsp_valid_o, rsp_ready_o, fetch_stall_o} !== 3'b001) begin errors++; $display("FAIL m1_t1: got %b exp 001", {rsp_valid_o, rsp_ready_o, fetch_stall_o}); end
    tick();
    checks++; if (rsp_valid_o !== 1'b1) begin errors++; $display("FAIL m1_rspv: got %b exp 1", rsp_valid_o); end
    checks++; if ({rsp_rob_idx_o, rsp_vaddr_o, rsp_excp_o} !== {6'd5, 32'h0000_0A31, 7'h00}) begin errors++; $display("FAIL m1_fields: got %0d %h %h exp 5 00000a31 00", rsp_rob_idx_o, rsp_vaddr_o, rsp_excp_o); end
    checks++; if (tag_en_o !== 1'b0) begin errors++; $display("FAIL m1_resp_en: got %b exp 0", tag_en_o); end
    tick();
    checks++; if ({rsp_valid_o, rsp_ready_o} !== 2'b01) begin errors++; $display("FAIL m1_idle: got %b exp 01", {rsp_valid_o, rsp_ready_o}); end
    $display("mode1 index invalidate: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_hit_inval();
    trans_rsp_valid_i = 1'b1;
    trans_rsp_paddr_i = 32'h1234_5A30;
    trans_rsp_excp_i  = 7'h00;
    tag_rdata_i[0]    = {1'b1, 20'h12345};
    tag_rdata_i[1]    = {1'b1, 20'h54321};
    issue(2'd2, 32'h0000_5A30, 6'd7);
    checks++; if ({trans_req_valid_o, trans_req_vaddr_o} !== {1'b1, 32'h0000_5A30}) begin errors++; $display("FAIL hit_trans: got %b %h exp 1 00005a30", trans_req_valid_o, trans_req_vaddr_o); end
    checks++; if ({tag_en_o, tag_we_o, tag_addr_o} !== {1'b1, 2'b00, 8'hA3}) begin errors++; $display("FAIL hit_read: got %b %b %h exp 1 00 a3", tag_en_o, tag_we_o, tag_addr_o); end
    tick();
    checks++; if ({tag_en_o, tag_we_o, rsp_valid_o} !== 4'b1010) begin errors++; $display("FAIL hit_cmp: got %b exp 1010", {tag_en_o, tag_we_o, rsp_valid_o}); end
    tick();
    checks++; if ({rsp_valid_o, rsp_rob_idx_o, rsp_excp_o} !== {1'b1, 6'd7, 7'h00}) begin errors++; $display("FAIL hit_rsp: got %b %0d %h exp 1 7 00", rsp_valid_o, rsp_rob_idx_o, rsp_excp_o); end
    tick();
    $display("mode2 hit: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_miss();
    tag_rdata_i[0] = {1'b0, 20'h12345};
    tag_rdata_i[1] = {1'b1, 20'h12346};
    issue(2'd2, 32'h0000_5A31, 6'd8);
    tick();
    checks++; if ({tag_en_o, tag_we_o, rsp_valid_o} !== 4'b0000) begin errors++; $display("FAIL miss_cmp: got %b exp 0000", {tag_en_o, tag_we_o, rsp_valid_o}); end
    tick();
    checks++; if ({rsp_valid_o, rsp_rob_idx_o} !== {1'b1, 6'd8}) begin errors++; $display("FAIL miss_rsp: got %b %0d exp 1 8", rsp_valid_o, rsp_rob_idx_o); end
    tick();
    $display("mode2 miss: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_trans_excp();
    trans_rsp_excp_i = 7'h7F;
    issue(2'd2, 32'h0000_1230, 6'd9);
    checks++; if ({trans_req_valid_o, tag_en_o} !== 2'b10) begin errors++; $display("FAIL excp_trans: got %b exp 10", {trans_req_valid_o, tag_en_o}); end
    tick();
    checks++; if ({rsp_valid_o, rsp_excp_o, tag_en_o} !== {1'b1, 7'h7F, 1'b0}) begin errors++; $display("FAIL excp_rsp: got %b %h %b exp 1 7f 0", rsp_valid_o, rsp_excp_o, tag_en_o); end
    tick();
    trans_rsp_excp_i = 7'h00;
    $display("mode2 exception: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_noop();
    issue(2'd3, 32'h0000_0FF0, 6'd11);
    checks++; if ({rsp_valid_o, rsp_rob_idx_o, rsp_excp_o, tag_en_o} !== {1'b1, 6'd11, 7'h00, 1'b0}) begin errors++; $display("FAIL noop_rsp: got %b %0d %h %b exp 1 11 00 0", rsp_valid_o, rsp_rob_idx_o, rsp_excp_o, tag_en_o); end
    tick();
    $display("mode3 noop: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_back_to_back();
    req_ready_i = 1'b0;
    issue(2'd0, 32'h0000_0120, 6'd12);
    checks++; if ({tag_en_o, tag_we_o, tag_addr_o} !== {1'b1, 2'b01, 8'h12}) begin errors++; $display("FAIL bp_write: got %b %b %h exp 1 01 12", tag_en_o, tag_we_o, tag_addr_o); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if ({rsp_valid_o, rsp_ready_o, rsp_rob_idx_o, rsp_vaddr_o} !== {2'b10, 6'd12, 32'h0000_0120}) begin errors++; $display("FAIL bp_hold%0d: got %b%b %0d %h exp 10 12 00000120", i, rsp_valid_o, rsp_ready_o, rsp_rob_idx_o, rsp_vaddr_o); end
    end
    req_ready_i   = 1'b1;
    req_valid_i   = 1'b1;
    req_mode_i    = 2'd3;
    req_rob_idx_i = 6'd13;
    tick();
    req_valid_i = 1'b0;
    checks++; if ({rsp_valid_o, rsp_ready_o, fetch_stall_o} !== 3'b010) begin errors++; $display("FAIL bp_release: got %b exp 010", {rsp_valid_o, rsp_ready_o, fetch_stall_o}); end
    tick();
    checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL bp_noaccept: got %b exp 0", rsp_valid_o); end
    $display("backpressure: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_flush();
    trans_rsp_valid_i = 1'b0;
    issue(2'd2, 32'h0000_3340, 6'd20);
    tick();
    checks++; if ({trans_req_valid_o, tag_en_o} !== 2'b10) begin errors++; $display("FAIL fl_wait: got %b exp 10", {trans_req_valid_o, tag_en_o}); end
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    checks++; if ({rsp_valid_o, rsp_ready_o, fetch_stall_o, trans_req_valid_o} !== 4'b0100) begin errors++; $display("FAIL fl_trans: got %b exp 0100", {rsp_valid_o, rsp_ready_o, fetch_stall_o, trans_req_valid_o}); end
    tick();
    checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL fl_norsp: got %b exp 0", rsp_valid_o); end
    // flush beats acceptance
    flush_i = 1'b1;
    issue(2'd1, 32'h0000_0001, 6'd21);
    flush_i = 1'b0;
    checks++; if ({fetch_stall_o, tag_en_o} !== 2'b00) begin errors++; $display("FAIL fl_prio: got %b exp 00", {fetch_stall_o, tag_en_o}); end
    // flush in WRITE: write still on the port, then idle
    issue(2'd1, 32'h0000_0001, 6'd22);
    flush_i = 1'b1;
    #1;
    checks++; if ({tag_en_o, tag_we_o} !== 3'b110) begin errors++; $display("FAIL fl_write: got %b exp 110", {tag_en_o, tag_we_o}); end
    tick();
    flush_i = 1'b0;
    checks++; if ({rsp_valid_o, rsp_ready_o, tag_en_o} !== 3'b010) begin errors++; $display("FAIL fl_write_idle: got %b exp 010", {rsp_valid_o, rsp_ready_o, tag_en_o}); end
    trans_rsp_valid_i = 1'b1;
    $display("flush: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_reset_mid();
    issue(2'd1, 32'h0000_0A31, 6'd30);
    a_rst_n = 1'b0;
    #1;
    checks++; if ({tag_en_o, fetch_stall_o, rsp_ready_o, rsp_rob_idx_o} !== {3'b001, 6'd0}) begin errors++; $display("FAIL rm_async: got %b %b %b %0d exp 0 0 1 0", tag_en_o, fetch_stall_o, rsp_ready_o, rsp_rob_idx_o); end
    #4 a_rst_n = 1'b1;
    tick();
    checks++; if ({rsp_valid_o, tag_en_o} !== 2'b00) begin errors++; $display("FAIL rm_after: got %b exp 00", {rsp_valid_o, tag_en_o}); end
    $display("reset mid-op: checks=%0d errors=%0d", checks, errors);
  endtask

  initial begin
    flush_i = 1'b0; req_valid_i = 1'b0; req_vaddr_i = '0; req_rob_idx_i = '0;
    req_mode_i = '0; req_ready_i = 1'b1; trans_rsp_valid_i = 1'b0;
    trans_rsp_paddr_i = '0; trans_rsp_excp_i = '0; tag_rdata_i = '0;
    test_reset();
    test_index_inval();
    test_hit_inval();
    test_miss();
    test_trans_excp();
    test_noop();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
